// File: rtl/tlc_phase_sequencer_if.sv
// Board-side bundle of the phase sequencer:
// sensor/preempt inputs, lamp drives and status.
interface tlc_phase_sequencer_if;
  logic       farmSensor;
  logic       preempt;
  logic [1:0] highwaySignal;
  logic [1:0] farmSignal;
  logic [2:0] state;
  logic       phaseStart;

  modport master (
    output farmSensor,
    output preempt,
    input  highwaySignal,
    input  farmSignal,
    input  state,
    input  phaseStart
  );

  modport slave (
    input  farmSensor,
    input  preempt,
    output highwaySignal,
    output farmSignal,
    output state,
    output phaseStart
  );
endinterface

// File: rtl/tlc_phase_sequencer.sv
// Highway/farm intersection sequencer with its own
// prescaled phase timer, farm request latch and preemption.
module tlc_phase_sequencer #(
  parameter int unsigned TICK_DIV      = 100_000_000,
  parameter int unsigned HWY_MIN_GREEN = 30,
  parameter int unsigned YELLOW_T      = 3,
  parameter int unsigned ALLRED_T      = 1,
  parameter int unsigned FARM_MIN      = 5,
  parameter int unsigned FARM_MAX      = 15
) (
  input logic                  Clk,
  input logic                  Rst,
  tlc_phase_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    INIT        = 3'd0,
    HWY_GREEN   = 3'd1,
    HWY_YELLOW  = 3'd2,
    ALLRED_HF   = 3'd3,
    FARM_GREEN  = 3'd4,
    FARM_YELLOW = 3'd5,
    ALLRED_FH   = 3'd6
  } state_t;

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  localparam logic [7:0] AR_LAST   = 8'(ALLRED_T - 1);
  localparam logic [7:0] Y_LAST    = 8'(YELLOW_T - 1);
  localparam logic [7:0] FMAX_LAST = 8'(FARM_MAX - 1);
  localparam logic [7:0] HMIN      = 8'(HWY_MIN_GREEN);
  localparam logic [7:0] HMIN_LAST = 8'(HWY_MIN_GREEN - 1);
  localparam logic [7:0] FMIN      = 8'(FARM_MIN);
  localparam logic [7:0] FMIN_LAST = 8'(FARM_MIN - 1);

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] pre_q;
  logic [7:0]    cnt_q;
  logic [1:0]    farm_sync;
  logic [1:0]    pre_sync;
  logic          farm_req;
  logic          started;
  logic [1:0]    hwy_q;
  logic [1:0]    farm_q;
  logic [1:0]    hwy_d;
  logic [1:0]    farm_d;
  logic          ps_q;

  logic tick;
  logic farm_s;
  logic pre_s;
  logic change;
  logic done_ar;
  logic done_y;
  logic done_fmax;
  logic hmin_ok;
  logic fmin_ok;

  assign farm_s    = farm_sync[1];
  assign pre_s     = pre_sync[1];
  assign tick      = (pre_q == PRE_MAX);
  assign change    = (state_d != state_q);
  assign done_ar   = tick && (cnt_q == AR_LAST);
  assign done_y    = tick && (cnt_q == Y_LAST);
  assign done_fmax = tick && (cnt_q == FMAX_LAST);
  // a minimum counts as reached on the edge that completes its last tick
  assign hmin_ok   = (cnt_q >= HMIN) ||
                     (tick && (cnt_q == HMIN_LAST));
  assign fmin_ok   = (cnt_q >= FMIN) ||
                     (tick && (cnt_q == FMIN_LAST));

  // two-flop synchronizers for the asynchronous board inputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      farm_sync <= 2'b00;
      pre_sync  <= 2'b00;
    end else begin
      farm_sync <= {farm_sync[0], bus.farmSensor};
      pre_sync  <= {pre_sync[0], bus.preempt};
    end
  end

  // next-state rules for each phase
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:
        if (done_ar) state_d = HWY_GREEN;
      HWY_GREEN:
        if (hmin_ok && farm_req && !pre_s)
          state_d = HWY_YELLOW;
      HWY_YELLOW:
        if (done_y) state_d = ALLRED_HF;
      ALLRED_HF:
        if (done_ar)
          state_d = pre_s ? HWY_GREEN : FARM_GREEN;
      FARM_GREEN:
        if (pre_s || (fmin_ok && !farm_s) || done_fmax)
          state_d = FARM_YELLOW;
      FARM_YELLOW:
        if (done_y) state_d = ALLRED_FH;
      ALLRED_FH:
        if (done_ar) state_d = HWY_GREEN;
      default:
        state_d = INIT;
    endcase
  end

  // lamp decode of the upcoming state
  always_comb begin
    hwy_d  = RED;
    farm_d = RED;
    unique case (1'b1)
      (state_d == HWY_GREEN):   hwy_d  = GREEN;
      (state_d == HWY_YELLOW):  hwy_d  = YELLOW;
      (state_d == FARM_GREEN):  farm_d = GREEN;
      (state_d == FARM_YELLOW): farm_d = YELLOW;
      default: ;
    endcase
  end

  // phase timer: prescaler and saturating tick count restart per state
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else if (change) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
      if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  // farm request latch; entry to farm green clears it and wins
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      farm_req <= 1'b0;
    end else if (state_d == FARM_GREEN &&
                 state_q != FARM_GREEN) begin
      farm_req <= 1'b0;
    end else if (farm_s && state_q != FARM_GREEN) begin
      farm_req <= 1'b1;
    end
  end

  // state register plus registered lamps and phase-start pulse
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= INIT;
      hwy_q   <= RED;
      farm_q  <= RED;
      ps_q    <= 1'b0;
      started <= 1'b0;
    end else begin
      state_q <= state_d;
      hwy_q   <= hwy_d;
      farm_q  <= farm_d;
      ps_q    <= change || !started;
      started <= 1'b1;
    end
  end

  assign bus.state         = state_q;
  assign bus.highwaySignal = hwy_q;
  assign bus.farmSignal    = farm_q;
  assign bus.phaseStart    = ps_q;

endmodule
